// File: rtl/conf_int_mac_acc_seq_if.sv
// Bundle of the control, operand-stream, MAC and result-stream signals for the
// dot-product sequencer. The slave side is the sequencer; master is its environment.
interface conf_int_mac_acc_seq_if #(
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int LEN_BITWIDTH       = 8
);
    logic                          start;
    logic [LEN_BITWIDTH-1:0]       len;
    logic                          busy;
    logic                          in_valid;
    logic [DATA_PATH_BITWIDTH-1:0] in_a;
    logic [DATA_PATH_BITWIDTH-1:0] in_b;
    logic                          in_ready;
    logic [DATA_PATH_BITWIDTH-1:0] mac_a;
    logic [DATA_PATH_BITWIDTH-1:0] mac_b;
    logic [DATA_PATH_BITWIDTH-1:0] mac_c_in;
    logic [DATA_PATH_BITWIDTH-1:0] mac_d;
    logic                          out_valid;
    logic [DATA_PATH_BITWIDTH-1:0] out_data;
    logic                          out_ready;

    modport master (
        output start, len, in_valid, in_a, in_b, mac_d, out_ready,
        input  busy, in_ready, mac_a, mac_b, mac_c_in, out_valid, out_data
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, mac_d, out_ready,
        output busy, in_ready, mac_a, mac_b, mac_c_in, out_valid, out_data
    );
endinterface

// File: rtl/conf_int_mac_acc_seq.sv
// Dot-product sequencer: streams len operand pairs through an external
// combinational MAC, accumulating modulo 2^DATA_PATH_BITWIDTH, then presents the sum.
module conf_int_mac_acc_seq #(
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int LEN_BITWIDTH       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    conf_int_mac_acc_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [LEN_BITWIDTH-1:0] CNT_ONE = {{(LEN_BITWIDTH-1){1'b0}}, 1'b1};

    state_e                        state_q, state_d;
    logic [DATA_PATH_BITWIDTH-1:0] acc_q, acc_d;
    logic [LEN_BITWIDTH-1:0]       cnt_q, cnt_d;

    logic                          busy_s;
    logic                          in_ready_s;
    logic [DATA_PATH_BITWIDTH-1:0] mac_a_s;
    logic [DATA_PATH_BITWIDTH-1:0] mac_b_s;
    logic [DATA_PATH_BITWIDTH-1:0] mac_c_in_s;
    logic                          out_valid_s;
    logic [DATA_PATH_BITWIDTH-1:0] out_data_s;

    // State, accumulator and remaining-count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; only the accept event and start in IDLE move the registers.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d = '0;
                    if (bus.len != '0) begin
                        cnt_d   = bus.len;
                        state_d = ST_ACC;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (bus.in_valid) begin
                    acc_d = bus.mac_d;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the state register; rst forces every output quiet
    // even before the reset edge has landed.
    always_comb begin
        busy_s      = 1'b0;
        in_ready_s  = 1'b0;
        mac_a_s     = '0;
        mac_b_s     = '0;
        mac_c_in_s  = '0;
        out_valid_s = 1'b0;
        out_data_s  = '0;
        if (rst) begin
            busy_s = 1'b0;
        end else begin
            busy_s = (state_q != ST_IDLE);
            case (state_q)
                ST_ACC: begin
                    in_ready_s = 1'b1;
                    mac_a_s    = bus.in_a;
                    mac_b_s    = bus.in_b;
                    mac_c_in_s = acc_q;
                end
                ST_DONE: begin
                    out_valid_s = 1'b1;
                    out_data_s  = acc_q;
                end
                default: begin
                    in_ready_s  = 1'b0;
                    out_valid_s = 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_s;
    assign bus.in_ready  = in_ready_s;
    assign bus.mac_a     = mac_a_s;
    assign bus.mac_b     = mac_b_s;
    assign bus.mac_c_in  = mac_c_in_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = out_data_s;

endmodule

// File: tb/tb_conf_int_mac_acc_seq.sv
// Directed bench for conf_int_mac_acc_seq with a behavioural MAC and
// hand-computed expected sums.
module tb_conf_int_mac_acc_seq;

    localparam int W = 16;
    localparam int L = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    conf_int_mac_acc_seq_if #(.DATA_PATH_BITWIDTH(W), .LEN_BITWIDTH(L)) bus ();

    conf_int_mac_acc_seq #(.DATA_PATH_BITWIDTH(W), .LEN_BITWIDTH(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // downstream combinational MAC, truncated to W bits
    assign bus.mac_d = bus.mac_a * bus.mac_b + bus.mac_c_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b1; bus.len = 8'd3; bus.in_valid = 1'b1;
        bus.in_a = 16'd9; bus.in_b = 16'd9; bus.out_ready = 1'b1;
        tick(); tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d exp=0", bus.busy); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0d exp=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0d exp=0", bus.out_valid); end
        total++; if ({bus.mac_a, bus.mac_b, bus.mac_c_in, bus.out_data} !== 64'd0) begin
            bad++; $display("FAIL rst_data_outs got=%0h exp=0", {bus.mac_a, bus.mac_b, bus.mac_c_in, bus.out_data}); end
        rst = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_a = 16'd0; bus.in_b = 16'd0;
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%0d exp=0", bus.busy); end
    endtask

    // len=3, pairs (2,3),(4,5),(1,7) -> 6, 26, 33; 'gaps' idle cycles between pairs
    task automatic test_run_33(input int gaps, input string tag);
        logic [15:0] av [3];
        logic [15:0] bv [3];
        logic [15:0] ec [3];
        av = '{16'd2, 16'd4, 16'd1};
        bv = '{16'd3, 16'd5, 16'd7};
        ec = '{16'd0, 16'd6, 16'd26};
        bus.start = 1'b1; bus.len = 8'd3; #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s_idle_busy got=%0d exp=0", tag, bus.busy); end
        tick();
        bus.start = 1'b0; bus.len = 8'd1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_a = av[i]; bus.in_b = bv[i]; #1;
            total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
                bad++; $display("FAIL %s_ready%0d got=%0d%0d exp=11", tag, i, bus.in_ready, bus.busy); end
            total++; if (bus.mac_c_in !== ec[i] || bus.mac_a !== av[i] || bus.mac_b !== bv[i]) begin
                bad++; $display("FAIL %s_mac%0d got c=%0d a=%0d b=%0d exp c=%0d", tag, i, bus.mac_c_in, bus.mac_a, bus.mac_b, ec[i]); end
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL %s_early_valid%0d got=1 exp=0", tag, i); end
            tick();
            if (i < 2) begin
                for (int g = 0; g < gaps; g++) begin
                    bus.in_valid = 1'b0; bus.in_a = 16'hAAAA; #1;
                    total++; if (bus.mac_c_in !== ec[i+1] || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                        bad++; $display("FAIL %s_stall%0d got c=%0d rdy=%0d ov=%0d exp c=%0d rdy=1 ov=0", tag, i, bus.mac_c_in, bus.in_ready, bus.out_valid, ec[i+1]); end
                    tick();
                end
            end
        end
        bus.in_valid = 1'b0; #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd33) begin
            bad++; $display("FAIL %s_result got v=%0d d=%0d exp v=1 d=33", tag, bus.out_valid, bus.out_data); end
        total++; if (bus.in_ready !== 1'b0 || bus.mac_a !== 16'd0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL %s_done_outs got rdy=%0d a=%0d busy=%0d exp 0 0 1", tag, bus.in_ready, bus.mac_a, bus.busy); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0; #1;
        total++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 16'd0) begin
            bad++; $display("FAIL %s_back_idle got busy=%0d v=%0d d=%0d exp 0", tag, bus.busy, bus.out_valid, bus.out_data); end
    endtask

    task automatic test_wrap();
        bus.start = 1'b1; bus.len = 8'd2; tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 16'hFFFF; bus.in_b = 16'hFFFF; tick();
        bus.in_a = 16'h0002; bus.in_b = 16'h8000; #1;
        total++; if (bus.mac_c_in !== 16'h0001) begin bad++; $display("FAIL wrap_first got=%0h exp=0001", bus.mac_c_in); end
        tick();
        bus.in_valid = 1'b0; #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0001) begin
            bad++; $display("FAIL wrap_final got v=%0d d=%0h exp v=1 d=0001", bus.out_valid, bus.out_data); end
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    endtask

    task automatic test_zero_len();
        bus.start = 1'b1; bus.len = 8'd0; bus.in_valid = 1'b1; #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL zero_ready_idle got=%0d exp=0", bus.in_ready); end
        tick();
        bus.start = 1'b0; #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd0 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL zero_done got v=%0d d=%0d rdy=%0d exp 1 0 0", bus.out_valid, bus.out_data, bus.in_ready); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0; #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL zero_idle got=%0d exp=0", bus.busy); end
    endtask

    // backpressure in DONE, then back-to-back start with len changed mid-run
    task automatic test_back_to_back();
        bus.start = 1'b1; bus.len = 8'd1; tick();
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_a = 16'd3; bus.in_b = 16'd4; tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.start = k[0]; bus.len = 8'(k + 2); #1;
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd12 || bus.in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d got v=%0d d=%0d rdy=%0d exp 1 12 0", k, bus.out_valid, bus.out_data, bus.in_ready); end
            tick();
        end
        bus.start = 1'b0; bus.out_ready = 1'b1; tick();
        bus.out_ready = 1'b0; bus.start = 1'b1; bus.len = 8'd1; #1;
        total++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release got busy=%0d v=%0d exp 0 0", bus.busy, bus.out_valid); end
        tick();
        bus.start = 1'b0; bus.len = 8'd7; bus.in_valid = 1'b1; bus.in_a = 16'd5; bus.in_b = 16'd5; #1;
        total++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.mac_c_in !== 16'd0) begin
            bad++; $display("FAIL b2b_start got busy=%0d rdy=%0d c=%0d exp 1 1 0", bus.busy, bus.in_ready, bus.mac_c_in); end
        tick();
        bus.in_valid = 1'b0; #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd25) begin
            bad++; $display("FAIL b2b_result got v=%0d d=%0d exp 1 25", bus.out_valid, bus.out_data); end
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bus.start = 1'b1; bus.len = 8'd3; tick();
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_a = 16'd2; bus.in_b = 16'd3; tick();
        rst = 1'b1; bus.in_a = 16'd4; bus.in_b = 16'd5; bus.out_ready = 1'b1; #1;
        total++; if (bus.in_ready !== 1'b0 || bus.mac_a !== 16'd0 || bus.mac_c_in !== 16'd0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL mid_rst_during got rdy=%0d a=%0d c=%0d busy=%0d exp 0", bus.in_ready, bus.mac_a, bus.mac_c_in, bus.busy); end
        tick();
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; #1;
        total++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 16'd0) begin
            bad++; $display("FAIL mid_rst_after got busy=%0d v=%0d d=%0d exp 0", bus.busy, bus.out_valid, bus.out_data); end
        bus.start = 1'b1; bus.len = 8'd1; tick();
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_a = 16'd6; bus.in_b = 16'd7; #1;
        total++; if (bus.mac_c_in !== 16'd0) begin bad++; $display("FAIL mid_rst_acc got=%0d exp=0", bus.mac_c_in); end
        tick();
        bus.in_valid = 1'b0; #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd42) begin
            bad++; $display("FAIL mid_rst_fresh got v=%0d d=%0d exp 1 42", bus.out_valid, bus.out_data); end
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_run_33(0, "basic");
        test_run_33(2, "stall");
        test_wrap();
        test_zero_len();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conf_int_mac_acc_seq.md
CONF_INT_MAC_ACC_SEQ -- requirements
Module: conf_int_mac_acc_seq

Interface
REQ-001 SHALL have parameter DATA_PATH_BITWIDTH, default 16: width of operands, accumulator and result.
REQ-002 SHALL have parameter LEN_BITWIDTH, default 8: width of the vector-length field.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a new dot product; sampled only in IDLE.
REQ-006 SHALL have port len, input, LEN_BITWIDTH: number of operand pairs; sampled with start.
REQ-007 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 SHALL have port in_valid, input, 1 bit: operand pair valid.
REQ-009 SHALL have ports in_a and in_b, input, DATA_PATH_BITWIDTH each: operand pair.
REQ-010 SHALL have port in_ready, output, 1 bit: sequencer accepts the operand pair.
REQ-011 SHALL have ports mac_a, mac_b and mac_c_in, output, DATA_PATH_BITWIDTH each: operands driven to the downstream combinational MAC.
REQ-012 SHALL have port mac_d, input, DATA_PATH_BITWIDTH: MAC result, equal to mac_a*mac_b+mac_c_in truncated.
REQ-013 SHALL have port out_valid, output, 1 bit: result valid.
REQ-014 SHALL have port out_data, output, DATA_PATH_BITWIDTH: final accumulated result.
REQ-015 SHALL have port out_ready, input, 1 bit: consumer accepts the result.

Function
REQ-016 SHALL implement an FSM with states IDLE, ACC and DONE, plus registers acc (DATA_PATH_BITWIDTH) and cnt (LEN_BITWIDTH).
REQ-017 IDLE, start=1, len!=0: SHALL load acc<=0 and cnt<=len, and enter ACC on the next edge.
REQ-018 IDLE, start=1, len==0: SHALL load acc<=0 and enter DONE directly; no operands are consumed.
REQ-019 IDLE, start=0: SHALL hold all state.
REQ-020 start SHALL be ignored in ACC and DONE.
REQ-021 In ACC: in_ready=1, mac_a=in_a, mac_b=in_b, mac_c_in=acc; all combinational.
REQ-022 Outside ACC: in_ready=0, and mac_a, mac_b and mac_c_in SHALL all be 0.
REQ-023 Accept event: in_valid&&in_ready. On each accept, acc<=mac_d and cnt<=cnt-1.
REQ-024 In ACC with in_valid=0: SHALL hold acc and cnt; stalls are unbounded.
REQ-025 Accept with cnt==1: SHALL enter DONE on the same edge that captures the final acc.
REQ-026 Latency: out_valid SHALL rise exactly 1 cycle after the last accept.
REQ-027 In DONE: out_valid=1 and out_data=acc; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 DONE with out_ready=1: SHALL return to IDLE on the next edge, with out_valid low from that edge.
REQ-029 Outside DONE: out_valid=0 and out_data=0.
REQ-030 Arithmetic SHALL be unsigned modulo 2^DATA_PATH_BITWIDTH. Overflow wraps silently, with no saturation and no flag; the block relies on mac_d being already truncated.
REQ-031 Back-to-back runs: a start asserted in the first IDLE cycle after DONE SHALL be honoured, giving a minimum 1-cycle gap between runs.
REQ-032 len is captured at start; later changes on len SHALL have no effect on the current run.
REQ-033 The block SHALL have no combinational path from out_ready to in_ready, nor from in_valid to out_valid.

Reset
REQ-034 rst=1 at a clock edge SHALL force IDLE, acc=0 and cnt=0; rst SHALL override start, in_valid and out_ready in that cycle.
REQ-035 While rst=1 and after reset: busy=0, in_ready=0, out_valid=0, out_data=0, mac_a=0, mac_b=0, mac_c_in=0.
REQ-036 Reset mid-operation, in ACC or DONE, SHALL abort the run. The partial result is discarded and never presented.

Verification
REQ-037 SHALL cover a basic run: start, len=3; pairs (2,3), (4,5), (1,7) with in_valid held high. Required: out_valid 1 cycle after the 3rd accept, out_data=33, busy high from cycle after start until the cycle after the out_ready handshake.
REQ-038 SHALL cover stalls: as REQ-037, with in_valid low for 2 cycles between every pair. Required: the same result 33, with acc and cnt unchanged during the gaps.
REQ-039 SHALL cover wrap: width 16, len=2, pairs (0xFFFF,0xFFFF) then (0x0002,0x8000). Required: first acc 0x0001, final out_data 0x0001.
REQ-040 SHALL cover zero length: start, len=0. Required: DONE one cycle later, out_data=0, in_ready never asserted.
REQ-041 SHALL cover backpressure: hold out_ready=0 for 5 cycles in DONE while toggling start and len. Required: out_valid and out_data stable, no new run started; out_ready=1 gives IDLE next cycle.
REQ-042 SHALL cover reset mid-run: assert rst after 1 of 3 accepts. Required: next cycle IDLE, outputs 0; a fresh run with len=1 and pair (6,7) yields 42.
